// File: rtl/lcd_btn_in_pio.sv
`default_nettype none
// ============================================================================
// Module   : lcd_btn_in_pio
// Brief    : Avalon-MM push-button input PIO with synchroniser, per-bit
//            debounce, edge capture and masked level interrupt.
//            Macro LCD_BTN_DEBOUNCE_EN enables the debounce filter.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_btn_in_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int IDLE_LEVEL      = 1,
    parameter int EDGE_POL        = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] c_idle      = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [1:0]       c_addr_data = 2'd0;
    localparam logic [1:0]       c_addr_mask = 2'd2;
    localparam logic [1:0]       c_addr_edge = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wr_clr;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= c_idle;
            r_sync2 <= c_idle;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LCD_BTN_DEBOUNCE_EN
    localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    // Counter tracks how long the synchronised bit has disagreed with stable.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_stable;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_stable <= c_idle[i];
            end else if (r_sync2[i] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt >= c_cnt_last) begin
                r_stable <= r_sync2[i];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end

        assign w_stable[i] = r_stable;
    end
`else
    logic w_unused_dbc;

    assign w_stable     = r_sync2;
    assign w_unused_dbc = (DEBOUNCE_CYCLES > 1);
`endif

    generate
        if (EDGE_POL == 0) begin : g_pol_fall
            assign w_edge = r_stable_d & ~w_stable;
        end else if (EDGE_POL == 1) begin : g_pol_rise
            assign w_edge = ~r_stable_d & w_stable;
        end else begin : g_pol_any
            assign w_edge = r_stable_d ^ w_stable;
        end
    endgenerate

    assign w_wr_clr = (w_wr && (address == c_addr_edge)) ? writedata[WIDTH-1:0] : '0;

    // A new edge is ORed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= c_idle;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_edgecap  <= (r_edgecap & ~w_wr_clr) | w_edge;
            if (w_wr && (address == c_addr_mask)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_addr_data: readdata[WIDTH-1:0] = w_stable;
            c_addr_mask: readdata[WIDTH-1:0] = r_irqmask;
            c_addr_edge: readdata[WIDTH-1:0] = r_edgecap;
            default:     readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_lcd_btn_in_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_btn_in_pio
// Brief    : Self-checking bench for lcd_btn_in_pio against a window-based
//            reference model; adapts to LCD_BTN_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_btn_in_pio;

    localparam int WIDTH = 4;
    localparam int DC    = 8;
`ifdef LCD_BTN_DEBOUNCE_EN
    localparam int         LAT        = 2 + DC;
    localparam logic [3:0] GLITCH_CAP = 4'h1;
`else
    localparam int         LAT        = 2;
    localparam logic [3:0] GLITCH_CAP = 4'h3;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] hist[$];
    logic [3:0] m_stable;
    logic [3:0] m_stable_d;
    logic [3:0] m_edgecap;
    logic [3:0] m_mask;

    lcd_btn_in_pio #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .IDLE_LEVEL     (1),
        .EDGE_POL       (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DC + 2; k++) hist.push_back(4'hF);
        m_stable   = 4'hF;
        m_stable_d = 4'hF;
        m_edgecap  = 4'h0;
        m_mask     = 4'h0;
    endtask

    // hist holds in_port as sampled at each edge; a bit settles once the
    // synchronised view of it has shown the opposite level for DC cycles.
    function automatic logic [3:0] settle(input logic [3:0] cur);
        logic [3:0] res;
        logic       flip;
        res = cur;
`ifdef LCD_BTN_DEBOUNCE_EN
        for (int b = 0; b < WIDTH; b++) begin
            flip = 1'b1;
            for (int k = 2; k <= DC + 1; k++) begin
                if (hist[hist.size() - 1 - k][b] == cur[b]) flip = 1'b0;
            end
            if (flip) res[b] = ~cur[b];
        end
`else
        flip = 1'b0;
        res  = hist[hist.size() - 2] ^ {4{flip}};
`endif
        return res;
    endfunction

    task automatic model_step();
        logic [3:0] next_stable;
        logic [3:0] clr;
        hist.push_back(in_port);
        next_stable = settle(m_stable);
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_edgecap = (m_edgecap & ~clr) | (m_stable_d & ~m_stable);
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        m_stable_d = m_stable;
        m_stable   = next_stable;
        while (hist.size() > DC + 2) void'(hist.pop_front());
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_stable};
            2'd2:    return {28'b0, m_mask};
            2'd3:    return {28'b0, m_edgecap};
            default: return 32'h0;
        endcase
    endfunction

    // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
    task automatic tick(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [3:0] inp);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        @(negedge clk);
        chk($sformatf("model_rd@%0d", a), readdata, exp_rd(a));
        chk("model_irq", 32'(irq), 32'(|(m_edgecap & m_mask)));
    endtask

    initial begin
        logic [3:0] rin;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        model_reset();
        @(negedge clk);
        tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            tick(2'(a), 1'b0, 1'b1, 32'h0, 4'hF);
            chk($sformatf("rst_a%0d", a), readdata, (a == 0) ? 32'hF : 32'h0);
            chk("rst_irq", 32'(irq), 32'h0);
        end

        for (int k = 1; k <= LAT; k++) begin
            tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hE);
            chk($sformatf("lat_data_c%0d", k), readdata, (k < LAT) ? 32'hF : 32'hE);
        end
        tick(2'd3, 1'b0, 1'b1, 32'h0, 4'hE);
        chk("lat_cap", readdata, 32'h1);

        for (int k = 0; k < 5; k++) tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hC);
        for (int k = 0; k < LAT + 2; k++) tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hE);
        chk("glitch_data", readdata, 32'hE);
        tick(2'd3, 1'b0, 1'b1, 32'h0, 4'hE);
        chk("glitch_cap", readdata, {28'b0, GLITCH_CAP});

        tick(2'd2, 1'b1, 1'b0, 32'h1, 4'hE);
        chk("mask_irq", 32'(irq), 32'h1);
        tick(2'd3, 1'b1, 1'b0, 32'h2, 4'hE);
        chk("clr_b1_cap", readdata, 32'h1);
        chk("clr_b1_irq", 32'(irq), 32'h1);
        tick(2'd3, 1'b1, 1'b0, 32'h1, 4'hE);
        chk("clr_b0_cap", readdata, 32'h0);
        chk("clr_b0_irq", 32'(irq), 32'h0);

        for (int k = 0; k < LAT + 2; k++) tick(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        chk("rise_nocap", readdata, 32'h0);
        for (int k = 1; k <= LAT; k++) tick(2'd3, 1'b0, 1'b1, 32'h0, 4'hE);
        chk("pre_set", readdata, 32'h0);
        tick(2'd3, 1'b1, 1'b0, 32'h1, 4'hE);
        chk("set_wins_cap", readdata, 32'h1);
        chk("set_wins_irq", 32'(irq), 32'h1);

        for (int k = 0; k < LAT + 2; k++) tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        for (int k = 0; k < 7; k++) tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hB);
        reset_n = 1'b0;
        model_reset();
        tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hB);
        chk("rst_mid_data", readdata, 32'hF);
        tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hB);
        reset_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick(2'd0, 1'b0, 1'b1, 32'h0, 4'hB);
            chk($sformatf("rel_data_c%0d", k), readdata, (k < LAT) ? 32'hF : 32'hB);
        end
        tick(2'd3, 1'b0, 1'b1, 32'h0, 4'hB);
        chk("rel_cap", readdata, 32'h4);
        chk("rel_irq", 32'(irq), 32'h0);

        rin = 4'hB;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) rin = rin ^ 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else if (!reset_n) begin
                reset_n = 1'b1;
            end
            tick(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 $urandom, rin);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
